// File: rtl/dpram_seq_fsm.sv
// dpram_seq_fsm: command sequencer for a dual-port RAM.
// Runs whole-memory FILL / INC / CLEAR and a single-word POKE, using both
// RAM ports in parallel. While idle it serves a read-only display port.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   button_code[2:0]      command (0 = none; 1 FILL, 2 INC, 3 CLEAR, 4 POKE)
//   display_addr          word shown while idle; POKE target
//   dout_a, dout_b        RAM read data (1-cycle synchronous read)
//   addr_a, addr_b        RAM addresses
//   din_a, din_b          RAM write data
//   wen_a, wen_b          RAM write enables
//   display_out           registered display word
//   busy                  operation in progress (WRALL/RD/WB)
//   done                  one-cycle pulse at end of each operation
module dpram_seq_fsm #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        button_code,
    input  logic [ADDR_W-1:0] display_addr,
    input  logic [DATA_W-1:0] dout_a,
    input  logic [DATA_W-1:0] dout_b,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] din_b,
    output logic              wen_a,
    output logic              wen_b,
    output logic [DATA_W-1:0] display_out,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] CMD_FILL  = 3'b001;
    localparam logic [2:0] CMD_INC   = 3'b010;
    localparam logic [2:0] CMD_CLEAR = 3'b011;
    localparam logic [2:0] CMD_POKE  = 3'b100;

    // Pointer value of the last even pair (DEPTH-2).
    localparam logic [ADDR_W-1:0] LAST_PTR = {{(ADDR_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRALL = 3'd1,
        S_RD    = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [ADDR_W-1:0] w_ptr_p1;
    logic [2:0]        r_cmd;
    logic [2:0]        w_cmd_nxt;
    logic [ADDR_W-1:0] r_poke_addr;
    logic [ADDR_W-1:0] w_poke_addr_nxt;
    logic [2:0]        r_btn_q;
    logic              w_accept;
    logic              w_is_poke;
    logic              w_is_fill;

    assign w_ptr_p1  = r_ptr + ADDR_W'(1);
    assign w_is_poke = (r_cmd == CMD_POKE);
    assign w_is_fill = (r_cmd == CMD_FILL);

    // Rising edge of a valid command while idle; a held button never retriggers.
    assign w_accept = (r_state == S_IDLE) && (button_code != 3'b000) &&
                      (r_btn_q == 3'b000) && (button_code <= CMD_POKE);

    // State, pointer, command latches and display register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_cmd       <= '0;
            r_poke_addr <= '0;
            r_btn_q     <= '0;
            display_out <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cmd       <= w_cmd_nxt;
            r_poke_addr <= w_poke_addr_nxt;
            r_btn_q     <= button_code;
            if (r_state == S_IDLE) begin
                display_out <= dout_b;
            end
        end
    end

    // Next-state and RAM-port decode from registered state.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_cmd_nxt       = r_cmd;
        w_poke_addr_nxt = r_poke_addr;
        addr_a          = '0;
        addr_b          = '0;
        din_a           = '0;
        din_b           = '0;
        wen_a           = 1'b0;
        wen_b           = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;

        case (r_state)
            S_IDLE: begin
                addr_b = display_addr;
                if (w_accept) begin
                    w_cmd_nxt       = button_code;
                    w_ptr_nxt       = '0;
                    w_poke_addr_nxt = display_addr;
                    if ((button_code == CMD_FILL) || (button_code == CMD_CLEAR)) begin
                        w_state_nxt = S_WRALL;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end

            S_WRALL: begin
                busy   = 1'b1;
                addr_a = r_ptr;
                addr_b = w_ptr_p1;
                wen_a  = 1'b1;
                wen_b  = 1'b1;
                if (w_is_fill) begin
                    din_a = DATA_W'(r_ptr);
                    din_b = DATA_W'(w_ptr_p1);
                end
                w_ptr_nxt = r_ptr + ADDR_W'(2);
                if (r_ptr == LAST_PTR) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_RD: begin
                busy = 1'b1;
                if (w_is_poke) begin
                    addr_a = r_poke_addr;
                end else begin
                    addr_a = r_ptr;
                    addr_b = w_ptr_p1;
                end
                w_state_nxt = S_WB;
            end

            // Read data for the addresses presented in RD is valid now.
            S_WB: begin
                busy  = 1'b1;
                din_a = dout_a + DATA_W'(1);
                din_b = dout_b + DATA_W'(1);
                wen_a = 1'b1;
                if (w_is_poke) begin
                    addr_a      = r_poke_addr;
                    w_state_nxt = S_DONE;
                end else begin
                    addr_a    = r_ptr;
                    addr_b    = w_ptr_p1;
                    wen_b     = 1'b1;
                    w_ptr_nxt = r_ptr + ADDR_W'(2);
                    if (r_ptr == LAST_PTR) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end

            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dpram_seq_fsm.sv
// Testbench for dpram_seq_fsm with a 16x16 dual-port RAM model.
// A behavioural model predicts busy/done timing per command and the
// resulting memory image; a compare step checks the DUT each cycle.
module tb_dpram_seq_fsm;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;

    logic          clk;
    logic          reset;
    logic [2:0]    button_code;
    logic [AW-1:0] display_addr;
    logic [DW-1:0] dout_a, dout_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b;
    logic          wen_a, wen_b;
    logic [DW-1:0] display_out;
    logic          busy, done;

    // RAM preload port (bench only)
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    logic [DW-1:0] ram [DEPTH];

    dpram_seq_fsm #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .button_code  (button_code),
        .display_addr (display_addr),
        .dout_a       (dout_a),
        .dout_b       (dout_b),
        .addr_a       (addr_a),
        .addr_b       (addr_b),
        .din_a        (din_a),
        .din_b        (din_b),
        .wen_a        (wen_a),
        .wen_b        (wen_b),
        .display_out  (display_out),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr] <= pre_data;
        end else begin
            if (wen_a) ram[addr_a] <= din_a;
            if (wen_b) ram[addr_b] <= din_b;
        end
        dout_a <= ram[addr_a];
        dout_b <= ram[addr_b];
    end

    // ---------------- behavioural model ----------------
    logic [DW-1:0] exp_mem [DEPTH];
    int            m_busy_left;
    bit            m_done_now;
    logic [2:0]    m_btn_q;
    int            idle_run;
    int            addr_run;
    logic [AW-1:0] m_prev_addr;
    bit            m_disturb;

    int n_checks;
    int n_pass;
    int tick_no;
    int cnt_busy;
    int cnt_done;
    int first_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit m_idle();
        return (m_busy_left == 0) && !m_done_now;
    endfunction

    // Predict the effect of the coming clock edge given the current inputs.
    task automatic model_edge();
        bit pre_idle;
        pre_idle = m_idle();
        if (m_disturb || !pre_idle) idle_run = 0;
        else idle_run++;
        m_disturb = 1'b0;
        if (display_addr == m_prev_addr) addr_run++;
        else addr_run = 1;
        m_prev_addr = display_addr;

        if (m_done_now) begin
            m_done_now = 1'b0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) m_done_now = 1'b1;
        end else if (button_code != 3'd0 && m_btn_q == 3'd0 && button_code <= 3'd4) begin
            case (button_code)
                3'd1: begin
                    for (int i = 0; i < DEPTH; i++) exp_mem[i] = DW'(i);
                    m_busy_left = DEPTH / 2;
                end
                3'd2: begin
                    for (int i = 0; i < DEPTH; i++) exp_mem[i] = exp_mem[i] + 16'd1;
                    m_busy_left = DEPTH;
                end
                3'd3: begin
                    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
                    m_busy_left = DEPTH / 2;
                end
                default: begin
                    exp_mem[display_addr] = exp_mem[display_addr] + 16'd1;
                    m_busy_left = 2;
                end
            endcase
        end
        m_btn_q = button_code;
    endtask

    // Per-cycle comparison against the model.
    task automatic check_outputs();
        tick_no++;
        if (busy) cnt_busy++;
        if (done) begin
            cnt_done++;
            if (first_done < 0) first_done = tick_no;
        end
        chk("busy", 32'(busy), 32'(m_busy_left > 0));
        chk("done", 32'(done), 32'(m_done_now));
        if (m_idle()) begin
            chk("idle_wen", {30'd0, wen_a, wen_b}, 32'd0);
            chk("idle_addr_b", 32'(addr_b), 32'(display_addr));
            if (idle_run >= 2 && addr_run >= 2)
                chk("display", 32'(display_out), 32'(exp_mem[display_addr]));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!m_idle() && n < 100) begin
            tick();
            n++;
        end
        chk("wait_idle_bound", 32'(n < 100), 32'd1);
        tick();
        tick();
    endtask

    task automatic press(input logic [2:0] code, input logic [AW-1:0] addr);
        button_code  = code;
        display_addr = addr;
        tick();
        button_code = 3'd0;
        wait_idle();
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        exp_mem[a] = d;
        m_disturb = 1'b1;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic mem_compare(input string name);
        for (int i = 0; i < DEPTH; i++) chk(name, 32'(ram[i]), 32'(exp_mem[i]));
    endtask

    task automatic clear_counts();
        tick_no = 0; cnt_busy = 0; cnt_done = 0; first_done = -1;
    endtask

    logic [DW-1:0] snap [DEPTH];

    initial begin
        n_checks = 0; n_pass = 0;
        m_busy_left = 0; m_done_now = 1'b0; m_btn_q = 3'd0;
        idle_run = 0; addr_run = 0; m_prev_addr = '0; m_disturb = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        clear_counts();
        reset = 1'b1; button_code = 3'd0; display_addr = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;

        // Reset values
        repeat (2) @(negedge clk);
        display_addr = 4'd7;
        #1;
        chk("rst_addr_a", 32'(addr_a), 32'd0);
        chk("rst_addr_b", 32'(addr_b), 32'd7);
        chk("rst_din", {din_a, din_b}, 32'd0);
        chk("rst_wen", {30'd0, wen_a, wen_b}, 32'd0);
        chk("rst_display", 32'(display_out), 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Define RAM contents, then idle for 10 cycles
        for (int i = 0; i < DEPTH; i++) preload(AW'(i), DW'($urandom));
        clear_counts();
        repeat (10) tick();
        chk("idle10_busy", 32'(cnt_busy), 32'd0);
        chk("idle10_done", 32'(cnt_done), 32'd0);

        // FILL pulse
        clear_counts();
        press(3'd1, 4'd0);
        chk("fill_busy_cycles", 32'(cnt_busy), 32'd8);
        chk("fill_done_count", 32'(cnt_done), 32'd1);
        chk("fill_done_cycle", 32'(first_done), 32'd9);
        for (int i = 0; i < DEPTH; i++) begin
            display_addr = AW'(i);
            tick();
            tick();
            chk("fill_sweep", 32'(display_out), i);
        end

        // INC twice
        for (int k = 0; k < 2; k++) begin
            clear_counts();
            press(3'd2, AW'($urandom));
            chk("inc_busy_cycles", 32'(cnt_busy), 32'd16);
            chk("inc_done_count", 32'(cnt_done), 32'd1);
        end
        for (int i = 0; i < DEPTH; i++) chk("inc2_lit", 32'(ram[i]), i + 2);
        mem_compare("inc2_model");

        // CLEAR then POKE 5 three times
        press(3'd3, 4'd0);
        clear_counts();
        for (int k = 0; k < 3; k++) press(3'd4, 4'd5);
        chk("poke_busy_cycles", 32'(cnt_busy), 32'd6);
        for (int i = 0; i < DEPTH; i++) chk("poke_lit", 32'(ram[i]), (i == 5) ? 32'd3 : 32'd0);

        // POKE wrap
        preload(4'd9, 16'hFFFF);
        tick();
        press(3'd4, 4'd9);
        chk("poke_wrap", 32'(ram[9]), 32'd0);
        mem_compare("poke_model");

        // Held INC
        clear_counts();
        button_code = 3'd2;
        repeat (60) tick();
        button_code = 3'd0;
        wait_idle();
        chk("hold_done_count", 32'(cnt_done), 32'd1);
        chk("hold_busy_cycles", 32'(cnt_busy), 32'd16);
        for (int i = 0; i < DEPTH; i++) chk("hold_lit", 32'(ram[i]), (i == 5) ? 32'd4 : 32'd1);

        // Randomized command stream
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) button_code = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) display_addr = AW'($urandom);
            tick();
        end
        button_code = 3'd0;
        wait_idle();
        mem_compare("random_mem");

        // Reset in cycle 4 of FILL
        for (int i = 0; i < DEPTH; i++) snap[i] = exp_mem[i];
        button_code = 3'd1;
        tick();            // acceptance edge
        button_code = 3'd0;
        tick(); tick(); tick();
        chk("fill_wen_before_reset", {30'd0, wen_a, wen_b}, 32'd3);
        reset = 1'b1;
        #1;
        chk("midrst_wen", {30'd0, wen_a, wen_b}, 32'd0);
        chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("midrst_addr_b", 32'(addr_b), 32'(display_addr));
        m_busy_left = 0; m_done_now = 1'b0; m_btn_q = 3'd0; idle_run = 0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = (i < 6) ? DW'(i) : snap[i];
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_counts();
        repeat (4) tick();
        chk("midrst_no_done", 32'(cnt_done), 32'd0);
        mem_compare("midrst_mem");
        for (int i = 0; i < 6; i++) chk("midrst_lit", 32'(ram[i]), i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
